// File: rtl/seq_approx_divider.sv
// Sequential 2N/N restoring divider: one quotient bit per cycle, MSB first, over one
// row of DW borrow-ripple subtractor cells, with optional approximate low-order cells.
module seq_approx_divider #(
  parameter int DW          = 8,
  parameter int APPROX_ROWS = 4,
  parameter int APPROX_COLS = 8
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            in_valid_i,
  output logic            in_ready_o,
  input  logic [2*DW-1:0] n_i,
  input  logic [DW-1:0]   d_i,
  input  logic            approx_en_i,
  output logic            out_valid_o,
  input  logic            out_ready_i,
  output logic [DW-1:0]   q_o,
  output logic [DW-1:0]   r_o,
  output logic            dz_o,
  output logic            ovf_o
);

  localparam int CW = (DW > 1) ? $clog2(DW) : 1;

  typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q;
  logic [DW-2:0]   n_lo_q;
  logic [DW-1:0]   d_q;
  logic            approx_q;
  logic            dz_q;
  logic            ovf_q;
  logic            top_q;
  logic [DW-1:0]   rem_q;
  logic [DW-1:0]   quot_q;
  logic [DW-1:0]   q_q;
  logic [DW-1:0]   r_q;
  logic            dz_out_q;
  logic            ovf_out_q;

  logic            accept;
  logic [DW-1:0]   diff;
  logic            borrow;
  logic            q_bit;
  logic [DW-1:0]   rem_next;

  always_comb begin
    state_d    = state_q;
    in_ready_o = (state_q == S_IDLE) || ((state_q == S_DONE) && out_ready_i);
    accept     = in_valid_i && in_ready_o;
    case (state_q)
      S_IDLE: if (accept) state_d = S_BUSY;
      S_BUSY: if (cnt_q == '0) state_d = S_DONE;
      S_DONE: begin
        if (accept)           state_d = S_BUSY;
        else if (out_ready_i) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // One subtractor row; cells below APPROX_ROWS/APPROX_COLS switch to the approximate form.
  always_comb begin
    logic x, y, b, use_apx;
    diff   = '0;
    borrow = 1'b0;
    for (int j = 0; j < DW; j++) begin
      x       = rem_q[j];
      y       = d_q[j];
      b       = borrow;
      use_apx = approx_q && (int'(cnt_q) < APPROX_ROWS) && (j < APPROX_COLS);
      if (use_apx) begin
        diff[j] = x | (y ^ b);
        borrow  = y | (~x & b);
      end else begin
        diff[j] = x ^ y ^ b;
        borrow  = (~x & y) | (~(x ^ y) & b);
      end
    end
    q_bit    = top_q | ~borrow;
    rem_next = q_bit ? diff : rem_q;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      n_lo_q    <= '0;
      d_q       <= '0;
      approx_q  <= 1'b0;
      dz_q      <= 1'b0;
      ovf_q     <= 1'b0;
      top_q     <= 1'b0;
      rem_q     <= '0;
      quot_q    <= '0;
      q_q       <= '0;
      r_q       <= '0;
      dz_out_q  <= 1'b0;
      ovf_out_q <= 1'b0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        n_lo_q   <= n_i[DW-2:0];
        d_q      <= d_i;
        approx_q <= approx_en_i;
        dz_q     <= (d_i == '0);
        ovf_q    <= (n_i[2*DW-1:DW] >= d_i);
        top_q    <= n_i[2*DW-1];
        rem_q    <= n_i[2*DW-2:DW-1];
        cnt_q    <= CW'(DW-1);
        quot_q   <= '0;
      end else if (state_q == S_BUSY) begin
        quot_q[cnt_q] <= q_bit;
        if (cnt_q != '0) begin
          top_q <= rem_next[DW-1];
          rem_q <= {rem_next[DW-2:0], n_lo_q[cnt_q - 1'b1]};
          cnt_q <= cnt_q - 1'b1;
        end else begin
          // Result registers change only here so they stay stable under back-pressure.
          q_q       <= {quot_q[DW-1:1], q_bit};
          r_q       <= rem_next;
          dz_out_q  <= dz_q;
          ovf_out_q <= ovf_q;
        end
      end
    end
  end

  assign out_valid_o = (state_q == S_DONE);
  assign q_o         = q_q;
  assign r_o         = r_q;
  assign dz_o        = dz_out_q;
  assign ovf_o       = ovf_out_q;

endmodule

// File: tb/tb_seq_approx_divider.sv
// Directed self-checking bench for seq_approx_divider with hand-computed results.
module tb_seq_approx_divider;

  localparam int DW = 8;

  logic            clk_i = 1'b0;
  logic            rst_i;
  logic            in_valid_i;
  logic            in_ready_o;
  logic [2*DW-1:0] n_i;
  logic [DW-1:0]   d_i;
  logic            approx_en_i;
  logic            out_valid_o;
  logic            out_ready_i;
  logic [DW-1:0]   q_o;
  logic [DW-1:0]   r_o;
  logic            dz_o;
  logic            ovf_o;

  int n_checks = 0;
  int n_pass   = 0;

  seq_approx_divider #(.DW(DW), .APPROX_ROWS(4), .APPROX_COLS(8)) dut (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .in_valid_i  (in_valid_i),
    .in_ready_o  (in_ready_o),
    .n_i         (n_i),
    .d_i         (d_i),
    .approx_en_i (approx_en_i),
    .out_valid_o (out_valid_o),
    .out_ready_i (out_ready_i),
    .q_o         (q_o),
    .r_o         (r_o),
    .dz_o        (dz_o),
    .ovf_o       (ovf_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  // Present operands for one edge; caller must ensure in_ready is high.
  task automatic issue(input logic [2*DW-1:0] n, input logic [DW-1:0] d, input logic ae);
    n_i = n; d_i = d; approx_en_i = ae; in_valid_i = 1'b1;
    tick();
    in_valid_i = 1'b0;
    n_i = 'x; d_i = 'x; approx_en_i = 1'bx;
  endtask

  // Count edges after accept until out_valid; expects exactly DW.
  task automatic wait_result(input string tag);
    int cyc = 0;
    while (!out_valid_o && cyc < 30) begin
      if (cyc < DW) check({tag, "_busy_ready"}, in_ready_o, 0);
      tick();
      cyc++;
    end
    check({tag, "_latency"}, cyc, DW);
  endtask

  task automatic op(input string tag, input logic [2*DW-1:0] n, input logic [DW-1:0] d,
                    input logic ae, input logic chk_qr, input logic [DW-1:0] eq,
                    input logic [DW-1:0] er, input logic edz, input logic eovf);
    check({tag, "_in_ready"}, in_ready_o, 1);
    issue(n, d, ae);
    wait_result(tag);
    if (chk_qr) begin
      check({tag, "_q"}, q_o, eq);
      check({tag, "_r"}, r_o, er);
    end
    check({tag, "_dz"}, dz_o, edz);
    check({tag, "_ovf"}, ovf_o, eovf);
  endtask

  task automatic drain();
    out_ready_i = 1'b1;
    tick();
    out_ready_i = 1'b0;
  endtask

  initial begin
    logic seen;
    rst_i = 1'b1; in_valid_i = 1'b0; out_ready_i = 1'b0;
    n_i = '0; d_i = '0; approx_en_i = 1'b0;
    tick(); tick();
    rst_i = 1'b0;
    check("rst_in_ready", in_ready_o, 1);
    check("rst_out_valid", out_valid_o, 0);
    check("rst_q", q_o, 0);
    check("rst_r", r_o, 0);
    check("rst_flags", {dz_o, ovf_o}, 0);

    op("exact", 16'd100, 8'd7, 1'b0, 1'b1, 8'd14, 8'd2, 1'b0, 1'b0);
    drain();
    check("idle_after_drain", out_valid_o, 0);

    op("approx", 16'd100, 8'd7, 1'b1, 1'b1, 8'h0F, 8'h7F, 1'b0, 1'b0);
    drain();

    op("divzero", 16'h1234, 8'd0, 1'b0, 1'b1, 8'hFF, 8'h34, 1'b1, 1'b1);
    drain();
    op("divzero_apx", 16'h1234, 8'd0, 1'b1, 1'b1, 8'hFF, 8'h34, 1'b1, 1'b1);
    drain();

    op("ovf", 16'h0900, 8'd8, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 1'b1);
    drain();

    // Back-pressure: result held for 5 cycles, then back-to-back accept.
    op("bp", 16'd1000, 8'd30, 1'b0, 1'b1, 8'd33, 8'd10, 1'b0, 1'b0);
    for (int k = 0; k < 5; k++) begin
      tick();
      check("bp_hold_valid", out_valid_o, 1);
      check("bp_hold_q", q_o, 8'd33);
      check("bp_hold_r", r_o, 8'd10);
      check("bp_hold_ready", in_ready_o, 0);
    end
    out_ready_i = 1'b1;
    #1;
    check("b2b_ready", in_ready_o, 1);
    n_i = 16'd200; d_i = 8'd9; approx_en_i = 1'b0; in_valid_i = 1'b1;
    tick();
    in_valid_i = 1'b0; out_ready_i = 1'b0;
    check("b2b_busy", out_valid_o, 0);
    check("b2b_old_q_held", q_o, 8'd33);
    wait_result("b2b");
    check("b2b_q", q_o, 8'd22);
    check("b2b_r", r_o, 8'd2);
    drain();

    // Reset during the third busy cycle aborts the operation.
    issue(16'd500, 8'd3, 1'b0);
    tick(); tick();
    rst_i = 1'b1;
    tick();
    rst_i = 1'b0;
    check("abort_in_ready", in_ready_o, 1);
    check("abort_q_cleared", q_o, 0);
    seen = 1'b0;
    for (int k = 0; k < 12; k++) begin
      if (out_valid_o) seen = 1'b1;
      tick();
    end
    check("abort_no_valid", seen, 0);

    op("post_rst", 16'd255, 8'd1, 1'b0, 1'b1, 8'hFF, 8'h00, 1'b0, 1'b0);
    drain();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
